// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UartTX among NREQ byte requesters
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int LOCK_TIMEOUT = 4340
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_load,
    output logic [15:0]       uart_in,
    input  logic [15:0]       uart_out,
    output logic [2:0]        grant_id,
    output logic              locked
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state;
    logic [15:0]     lock_cnt;
    logic            busy;
    logic            found;
    logic            accept;
    logic [IW-1:0]   cur;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] eligible;
    logic [7:0]      win_byte;
    logic            unused_status;

    assign busy          = uart_out[15];
    assign unused_status = ^uart_out[14:0];
    assign cur           = grant_id[IW-1:0];

    // A held lock narrows the field to the lock owner only.
    assign eligible = locked ? (req_valid & (NREQ'(1) << cur)) : req_valid;

    // Round-robin search begins just after the last granted index.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(cur) + k) % NREQ);
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign accept    = (state == IDLE) && !reset && !busy && found;
    assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;
    assign win_byte  = req_data[{win_idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            uart_load <= 1'b0;
            uart_in   <= 16'h0000;
            grant_id  <= 3'(NREQ - 1);
            locked    <= 1'b0;
            lock_cnt  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        uart_in   <= {8'h00, win_byte};
                        uart_load <= 1'b1;
                        grant_id  <= 3'(win_idx);
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    uart_load <= 1'b0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!busy) state <= IDLE;
                end
            endcase

            // Lock ages only while the owner sits idle with nothing to send.
            if (accept) begin
                lock_cnt <= 16'h0000;
                locked   <= !req_last[win_idx];
            end else if (!locked) begin
                lock_cnt <= 16'h0000;
            end else if (state == IDLE && !req_valid[cur]) begin
                if (lock_cnt == LOCK_LAST) begin
                    locked   <= 1'b0;
                    lock_cnt <= 16'h0000;
                end else begin
                    lock_cnt <= lock_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a busy-flag UartTX model
module tb_uart_tx_arbiter;
    localparam int NREQ     = 4;
    localparam int LT       = 4340;
    localparam int BUSY_LEN = 2170;
    localparam int DEPTH    = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [31:0]     req_data = '0;
    logic [NREQ-1:0] req_last = '0;
    logic [NREQ-1:0] req_ready;
    logic            uart_load;
    logic [15:0]     uart_in;
    logic [15:0]     uart_out;
    logic [2:0]      grant_id;
    logic            locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_req = 1'b1;
    logic ready_bad = 1'b0;
    logic ready_in_reset = 1'b0;

    logic [8:0] src_mem [NREQ][DEPTH];
    int         src_rd  [NREQ];
    int         src_wr  [NREQ];

    int          acc_cyc[$];
    int          acc_id[$];
    int          load_cyc[$];
    logic [15:0] load_byte[$];
    logic        load_lock[$];
    int          fall_q[$];

    logic ubusy = 1'b0;
    int   ucnt = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_load(uart_load),
        .uart_in(uart_in), .uart_out(uart_out), .grant_id(grant_id), .locked(locked)
    );

    always #5 clk = ~clk;

    assign uart_out = {ubusy, 15'h2AAA};

    always @(posedge clk) cyc <= cyc + 1;

    // UartTX: busy rises the cycle after load and stays high BUSY_LEN cycles.
    always @(posedge clk) begin
        if (uart_load) begin
            ubusy <= 1'b1;
            ucnt  <= BUSY_LEN;
        end else if (ucnt > 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) begin
                ubusy <= 1'b0;
                fall_q.push_back(cyc + 1);
            end
        end
    end

    always @(negedge clk) begin
        if (uart_load) begin
            load_cyc.push_back(cyc);
            load_byte.push_back(uart_in);
            load_lock.push_back(locked);
        end
    end

    task automatic push(input int id, input logic [7:0] data, input logic last);
        src_mem[id][src_wr[id]] = {last, data};
        src_wr[id]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++)
            if (src_rd[i] < src_wr[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        reset = rst_req;
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = src_mem[i][src_rd[i]][7:0];
                req_last[i]         = src_mem[i][src_rd[i]][8];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        #1;
        if (!$onehot0(req_ready)) ready_bad = 1'b1;
        if (reset && req_ready != '0) ready_in_reset = 1'b1;
        acc = req_ready & req_valid;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                acc_cyc.push_back(cyc);
                acc_id.push_back(i);
                src_rd[i]++;
            end
        end
        @(posedge clk);
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL %s_timeout: bytes still pending after %0d cycles, required none", name, budget);
        end
        repeat (BUSY_LEN + 10) step();
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        repeat (3) step();
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (uart_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", uart_load); end
        checks++; if (uart_in !== 16'h0000) begin errors++; $display("FAIL reset_uart_in: got %h expected 0000", uart_in); end
        checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL reset_grant_id: got %0d expected 3", grant_id); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        rst_req = 1'b0;
        step();
    endtask

    task automatic test_single();
        int a0, l0;
        a0 = acc_id.size();
        l0 = load_byte.size();
        push(0, 8'h41, 1'b1);
        push(0, 8'h42, 1'b1);
        drain(10000, "single");
        #1;
        checks++; if (load_byte.size() != l0 + 2) begin errors++; $display("FAIL single_count: got %0d loads expected 2", load_byte.size() - l0); end
        checks++; if (acc_id[a0] != 0) begin errors++; $display("FAIL single_id: got %0d expected 0", acc_id[a0]); end
        checks++; if (load_cyc[l0] != acc_cyc[a0] + 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", load_cyc[l0] - acc_cyc[a0]); end
        checks++; if (load_byte[l0] !== 16'h0041) begin errors++; $display("FAIL single_byte: got %h expected 0041", load_byte[l0]); end
        checks++; if (load_lock[l0] !== 1'b0) begin errors++; $display("FAIL single_locked: got %b expected 0", load_lock[l0]); end
        checks++; if (acc_cyc[a0+1] - load_cyc[l0] != BUSY_LEN + 2) begin errors++; $display("FAIL single_gap: got %0d expected %0d", acc_cyc[a0+1] - load_cyc[l0], BUSY_LEN + 2); end
        checks++; if (load_byte[l0+1] !== 16'h0042) begin errors++; $display("FAIL single_second: got %h expected 0042", load_byte[l0+1]); end
        checks++; if (uart_in !== 16'h0042 || uart_load !== 1'b0) begin errors++; $display("FAIL single_hold: got %h/%b expected 0042/0", uart_in, uart_load); end
    endtask

    task automatic test_contention();
        int a0, l0;
        int exp_id [5];
        logic [15:0] exp_b [5];
        exp_id = '{0, 1, 2, 3, 0};
        exp_b  = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00B0};
        push(0, 8'hA0, 1'b1);
        push(0, 8'hB0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        a0 = acc_id.size();
        l0 = load_byte.size();
        drain(20000, "contention");
        checks++; if (ready_in_reset !== 1'b0) begin errors++; $display("FAIL ready_in_reset: got %b expected 0", ready_in_reset); end
        checks++; if (load_byte.size() != l0 + 5) begin errors++; $display("FAIL cont_count: got %0d loads expected 5", load_byte.size() - l0); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (acc_id[a0+k] != exp_id[k]) begin errors++; $display("FAIL cont_id%0d: got %0d expected %0d", k, acc_id[a0+k], exp_id[k]); end
            checks++; if (load_byte[l0+k] !== exp_b[k]) begin errors++; $display("FAIL cont_byte%0d: got %h expected %h", k, load_byte[l0+k], exp_b[k]); end
        end
    endtask

    task automatic test_lock();
        int a0, l0;
        int exp_id [3];
        logic [15:0] exp_b [3];
        logic exp_l [3];
        exp_id = '{2, 2, 0};
        exp_b  = '{16'h0010, 16'h0011, 16'h0005};
        exp_l  = '{1'b1, 1'b0, 1'b0};
        a0 = acc_id.size();
        l0 = load_byte.size();
        push(2, 8'h10, 1'b0);
        push(2, 8'h11, 1'b1);
        push(0, 8'h05, 1'b1);
        drain(15000, "lock");
        checks++; if (load_byte.size() != l0 + 3) begin errors++; $display("FAIL lock_count: got %0d loads expected 3", load_byte.size() - l0); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (acc_id[a0+k] != exp_id[k]) begin errors++; $display("FAIL lock_id%0d: got %0d expected %0d", k, acc_id[a0+k], exp_id[k]); end
            checks++; if (load_byte[l0+k] !== exp_b[k]) begin errors++; $display("FAIL lock_byte%0d: got %h expected %h", k, load_byte[l0+k], exp_b[k]); end
            checks++; if (load_lock[l0+k] !== exp_l[k]) begin errors++; $display("FAIL lock_flag%0d: got %b expected %b", k, load_lock[l0+k], exp_l[k]); end
        end
    endtask

    task automatic test_timeout();
        int a0, l0;
        a0 = acc_id.size();
        l0 = load_byte.size();
        push(1, 8'h21, 1'b0);
        push(3, 8'h33, 1'b1);
        drain(20000, "timeout");
        checks++; if (acc_id[a0] != 1 || acc_id[a0+1] != 3) begin errors++; $display("FAIL tmo_ids: got %0d,%0d expected 1,3", acc_id[a0], acc_id[a0+1]); end
        checks++; if (load_byte[l0] !== 16'h0021 || load_byte[l0+1] !== 16'h0033) begin errors++; $display("FAIL tmo_bytes: got %h,%h expected 0021,0033", load_byte[l0], load_byte[l0+1]); end
        checks++; if (load_lock[l0] !== 1'b1) begin errors++; $display("FAIL tmo_locked: got %b expected 1", load_lock[l0]); end
        checks++; if (acc_cyc[a0+1] - acc_cyc[a0] != BUSY_LEN + 3 + LT) begin errors++; $display("FAIL tmo_release: got %0d expected %0d", acc_cyc[a0+1] - acc_cyc[a0], BUSY_LEN + 3 + LT); end
    endtask

    task automatic test_reset_mid();
        int a0, l0, f0;
        a0 = acc_id.size();
        l0 = load_byte.size();
        f0 = fall_q.size();
        push(0, 8'h50, 1'b1);
        for (int n = 0; n < 50 && load_byte.size() == l0; n++) step();
        repeat (20) step();
        push(0, 8'h51, 1'b1);
        push(1, 8'h52, 1'b1);
        rst_req = 1'b1;
        step();
        step();
        #1;
        checks++; if (grant_id !== 3'd3 || locked !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got id %0d lock %b expected 3/0", grant_id, locked); end
        checks++; if (uart_in !== 16'h0000 || uart_load !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got %h/%b expected 0000/0", uart_in, uart_load); end
        rst_req = 1'b0;
        drain(15000, "reset_mid");
        checks++; if (load_byte.size() != l0 + 3) begin errors++; $display("FAIL mid_count: got %0d loads expected 3", load_byte.size() - l0); end
        checks++; if (acc_cyc[a0+1] != fall_q[f0]) begin errors++; $display("FAIL mid_first_accept: got cycle %0d expected %0d", acc_cyc[a0+1], fall_q[f0]); end
        checks++; if (acc_id[a0+1] != 0 || load_byte[l0+1] !== 16'h0051) begin errors++; $display("FAIL mid_winner: got %0d/%h expected 0/0051", acc_id[a0+1], load_byte[l0+1]); end
        checks++; if (load_byte[l0+2] !== 16'h0052) begin errors++; $display("FAIL mid_second: got %h expected 0052", load_byte[l0+2]); end
        checks++; if (ready_bad !== 1'b0) begin errors++; $display("FAIL ready_onehot: got %b expected 0", ready_bad); end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
